// File: rtl/pwm_led_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared constants and state type for the three-channel PWM LED
//           driver.
// Revision: 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int               PWM_W   = 8;
    localparam logic [PWM_W-1:0] PWM_MAX = 8'hFF;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } pwmState_t;

endpackage
`default_nettype wire

// File: rtl/pwm_led_driver_channel.sv
`default_nettype none
// ============================================================================
// Module  : pwm_channel
// Brief   : One PWM channel: double-buffered duty shadow, 8-bit compare
//           against the shared period counter, registered LED pin.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter logic INVERT = 1'b0
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iLoad,
    input  logic             iIdle,
    input  logic [PWM_W-1:0] iPwmCnt,
    input  logic [PWM_W-1:0] iDuty,
    output logic             oPwm
);

    logic [PWM_W-1:0] rShadow;

    // Shadow tracks the live duty while idle and is reloaded only at the period wrap
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rShadow <= '0;
        end else if (iIdle || iLoad) begin
            rShadow <= iDuty;
        end
    end

    // Registered compare of the current counter and shadow, so the pin never glitches
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oPwm <= INVERT;
        end else if (iIdle) begin
            oPwm <= INVERT;
        end else begin
            oPwm <= (iPwmCnt < rShadow) ^ INVERT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_led_driver.sv
`default_nettype none
// ============================================================================
// Module  : pwm_led_driver
// Brief   : Three-channel 8-bit PWM generator for LED pins. Holds the run/idle
//           FSM, the clock prescaler, the shared period counter and the
//           period-start pulse; the per-channel logic lives in pwm_channel.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_led_driver
    import pwm_pkg::*;
#(
    parameter int   PRESCALE = 100,
    parameter logic INVERT   = 1'b0
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iEN,
    input  logic [PWM_W-1:0] iDUTYA,
    input  logic [PWM_W-1:0] iDUTYB,
    input  logic [PWM_W-1:0] iDUTYC,
    output logic             oPWMA,
    output logic             oPWMB,
    output logic             oPWMC,
    output logic             oPERIOD
);

    localparam int               PRE_W    = $clog2(PRESCALE > 1 ? PRESCALE : 2);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    pwmState_t           rState;
    pwmState_t           wNextState;
    logic                wRun;
    logic                wTick;
    logic                wWrap;
    logic                wIdle;
    logic [PRE_W-1:0]    rPrescale;
    logic [PWM_W-1:0]    rPwmCnt;
    logic [2:0][PWM_W-1:0] wDuty;
    logic [2:0]          wPwm;

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rState <= IDLE;
        end else begin
            rState <= wNextState;
        end
    end

    // Next state; dropping iEN in RUN wins over any tick, so counting only continues while enabled
    always_comb begin
        wNextState = rState;
        wRun       = 1'b0;
        case (rState)
            IDLE: begin
                if (iEN) begin
                    wNextState = RUN;
                end
            end
            RUN: begin
                if (!iEN) begin
                    wNextState = IDLE;
                end else begin
                    wRun = 1'b1;
                end
            end
            default: wNextState = IDLE;
        endcase
    end

    assign wIdle = (rState == IDLE);
    assign wTick = wRun && (rPrescale == PRE_LAST);
    assign wWrap = wTick && (rPwmCnt == PWM_MAX);

    // Prescaler and period counter; both held at zero whenever not actively running
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rPrescale <= '0;
            rPwmCnt   <= '0;
        end else if (!wRun) begin
            rPrescale <= '0;
            rPwmCnt   <= '0;
        end else begin
            rPrescale <= wTick ? '0 : rPrescale + 1'b1;
            if (wTick) begin
                rPwmCnt <= rPwmCnt + 1'b1;
            end
        end
    end

    // One-cycle pulse following the counter wrap, aligned with the shadow reload
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oPERIOD <= 1'b0;
        end else begin
            oPERIOD <= wWrap;
        end
    end

    assign wDuty = {iDUTYC, iDUTYB, iDUTYA};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            pwm_channel #(
                .INVERT (INVERT)
            ) uChannel (
                .iCLK    (iCLK),
                .iRST    (iRST),
                .iLoad   (wWrap),
                .iIdle   (wIdle),
                .iPwmCnt (rPwmCnt),
                .iDuty   (wDuty[gi]),
                .oPwm    (wPwm[gi])
            );
        end
    endgenerate

    assign oPWMA = wPwm[0];
    assign oPWMB = wPwm[1];
    assign oPWMC = wPwm[2];

endmodule
`default_nettype wire

// File: tb/tb_pwm_led_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_led_driver
// Brief   : Self-checking bench for pwm_led_driver: three instances
//           (PRESCALE=4, PRESCALE=4 inverted, PRESCALE=1) against an arithmetic
//           reference model based on elapsed clocks since enable.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pwm_led_driver;

    localparam int   PRE0 = 4;
    localparam int   PRE1 = 4;
    localparam int   PRE2 = 1;
    localparam logic INV0 = 1'b0;
    localparam logic INV1 = 1'b1;
    localparam logic INV2 = 1'b0;

    logic            clk;
    logic            rst;
    logic [2:0]      en;
    logic [2:0][7:0] dA;
    logic [2:0][7:0] dB;
    logic [2:0][7:0] dC;
    logic [2:0]      pA;
    logic [2:0]      pB;
    logic [2:0]      pC;
    logic [2:0]      per;

    int   nChecks;
    int   nFail;
    int   preOf [3];
    logic invOf [3];
    int   runK  [3];
    logic [7:0] lat [3][3];
    logic [3:0] expV [3];
    int   hiA [3];
    int   hiB [3];
    int   hiC [3];
    int   perCnt [3];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        int         hiA;
        int         hiB;
        int         hiC;
    } vec_t;

    vec_t tbl [4];

    pwm_led_driver #(.PRESCALE(PRE0), .INVERT(INV0)) uDut0 (
        .iCLK(clk), .iRST(rst), .iEN(en[0]),
        .iDUTYA(dA[0]), .iDUTYB(dB[0]), .iDUTYC(dC[0]),
        .oPWMA(pA[0]), .oPWMB(pB[0]), .oPWMC(pC[0]), .oPERIOD(per[0]));

    pwm_led_driver #(.PRESCALE(PRE1), .INVERT(INV1)) uDut1 (
        .iCLK(clk), .iRST(rst), .iEN(en[1]),
        .iDUTYA(dA[1]), .iDUTYB(dB[1]), .iDUTYC(dC[1]),
        .oPWMA(pA[1]), .oPWMB(pB[1]), .oPWMC(pC[1]), .oPERIOD(per[1]));

    pwm_led_driver #(.PRESCALE(PRE2), .INVERT(INV2)) uDut2 (
        .iCLK(clk), .iRST(rst), .iEN(en[2]),
        .iDUTYA(dA[2]), .iDUTYB(dB[2]), .iDUTYC(dC[2]),
        .oPWMA(pA[2]), .oPWMB(pB[2]), .oPWMC(pC[2]), .oPERIOD(per[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        nChecks++;
        if (act != req) begin
            nFail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: after the enable edge (k=0) the pin is inactive; after edge k>=1
    // it is active while ((k-1) mod period) < duty*PRESCALE, using the duty that
    // was sampled at the most recent period start.
    task automatic modelEdge(input int d);
        int period;
        int k;
        logic [7:0] cur [3];
        period = 256 * preOf[d];
        cur[0] = dA[d];
        cur[1] = dB[d];
        cur[2] = dC[d];
        if (rst) begin
            runK[d] = -1;
            expV[d] = {{3{invOf[d]}}, 1'b0};
        end else if (runK[d] < 0) begin
            expV[d] = {{3{invOf[d]}}, 1'b0};
            if (en[d]) begin
                runK[d] = 0;
                for (int ch = 0; ch < 3; ch++) lat[d][ch] = cur[ch];
            end
        end else begin
            k = runK[d] + 1;
            for (int ch = 0; ch < 3; ch++)
                expV[d][ch+1] = (((k - 1) % period) < (int'(lat[d][ch]) * preOf[d])) ^ invOf[d];
            expV[d][0] = en[d] && ((k % period) == 0);
            if (en[d]) begin
                runK[d] = k;
                if ((k % period) == 0)
                    for (int ch = 0; ch < 3; ch++) lat[d][ch] = cur[ch];
            end else begin
                runK[d] = -1;
            end
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        for (int d = 0; d < 3; d++) modelEdge(d);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("cycle dut%0d {C,B,A,PERIOD}", d),
                  int'({pC[d], pB[d], pA[d], per[d]}), int'(expV[d]));
            hiA[d]    += int'(pA[d]);
            hiB[d]    += int'(pB[d]);
            hiC[d]    += int'(pC[d]);
            perCnt[d] += int'(per[d]);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) stepClk();
    endtask

    task automatic clearCounts();
        for (int d = 0; d < 3; d++) begin
            hiA[d] = 0; hiB[d] = 0; hiC[d] = 0; perCnt[d] = 0;
        end
    endtask

    // Asserted between edges: outputs must go inactive without waiting for a clock
    task automatic doReset();
        rst = 1'b1;
        en  = 3'b000;
        #1;
        for (int d = 0; d < 3; d++) begin
            runK[d] = -1;
            check($sformatf("reset immediate dut%0d {C,B,A,PERIOD}", d),
                  int'({pC[d], pB[d], pA[d], per[d]}), int'({{3{invOf[d]}}, 1'b0}));
        end
        steps(2);
        rst = 1'b0;
    endtask

    initial begin
        nChecks  = 0;
        nFail    = 0;
        preOf[0] = PRE0; preOf[1] = PRE1; preOf[2] = PRE2;
        invOf[0] = INV0; invOf[1] = INV1; invOf[2] = INV2;
        for (int d = 0; d < 3; d++) begin
            runK[d] = -1;
            expV[d] = '0;
            for (int ch = 0; ch < 3; ch++) lat[d][ch] = '0;
        end
        clearCounts();
        rst = 1'b1;
        en  = 3'b000;
        dA  = '0; dB = '0; dC = '0;

        tbl[0] = '{8'h40, 8'h00, 8'hFF, 256,   0, 1020};
        tbl[1] = '{8'h01, 8'h80, 8'hFE,   4, 512, 1016};
        tbl[2] = '{8'h10, 8'hC0, 8'h7F,  64, 768,  508};
        tbl[3] = '{8'h00, 8'h02, 8'h55,   0,   8,  340};

        // Power-up reset, inverted instance idles high
        steps(3);
        check("reset inverted pin A", int'(pA[1]), 1);
        rst = 1'b0;
        steps(2);

        // Test 1: reset mid-period, then stay idle while iEN low
        dA[0] = 8'h40; dB[0] = 8'h20; dC[0] = 8'hFF;
        en[0] = 1'b1;
        steps(101);
        check("pre-reset A high", int'(pA[0]), 1);
        doReset();
        dA[0] = 8'h40; dB[0] = 8'h20; dC[0] = 8'hFF;
        steps(20);
        check("post-reset idle A", int'(pA[0]), 0);
        check("post-reset idle C", int'(pC[0]), 0);

        // Table: high clocks in the first full period for each duty set
        foreach (tbl[i]) begin
            en[0] = 1'b0;
            steps(2);
            dA[0] = tbl[i].a; dB[0] = tbl[i].b; dC[0] = tbl[i].c;
            en[0] = 1'b1;
            stepClk();
            clearCounts();
            steps(1024);
            check($sformatf("tbl%0d high A", i), hiA[0], tbl[i].hiA);
            check($sformatf("tbl%0d high B", i), hiB[0], tbl[i].hiB);
            check($sformatf("tbl%0d high C", i), hiC[0], tbl[i].hiC);
            check($sformatf("tbl%0d period pulses", i), perCnt[0], 1);
        end

        // Test 2/3: duty change mid-period takes effect only at the next period
        en[0] = 1'b0;
        steps(2);
        dA[0] = 8'h40; dB[0] = 8'h00; dC[0] = 8'hFF;
        en[0] = 1'b1;
        stepClk();
        clearCounts();
        for (int i = 1; i <= 1024; i++) begin
            stepClk();
            if (i == 100) dA[0] = 8'h80;
        end
        check("mid-change old period A", hiA[0], 256);
        check("mid-change pulse at wrap", int'(per[0]), 1);
        clearCounts();
        stepClk();
        check("new period first clk A", int'(pA[0]), 1);
        steps(1023);
        check("mid-change new period A", hiA[0] + 1, 512 + 1);
        check("new period B never high", hiB[0], 0);
        check("new period C high", hiC[0], 1020);
        check("new period pulses", perCnt[0], 1);

        // Test 4: drop iEN while A high, then re-enable with a new duty
        en[0] = 1'b0;
        steps(2);
        dA[0] = 8'h40;
        en[0] = 1'b1;
        steps(51);
        en[0] = 1'b0;
        stepClk();
        check("disable edge A still high", int'(pA[0]), 1);
        stepClk();
        check("one edge later A low", int'(pA[0]), 0);
        steps(5);
        dA[0] = 8'h10;
        en[0] = 1'b1;
        stepClk();
        check("re-enable first edge A", int'(pA[0]), 0);
        clearCounts();
        stepClk();
        check("re-enable second edge A", int'(pA[0]), 1);
        steps(1023);
        check("re-enable high A", hiA[0], 64);
        en[0] = 1'b0;
        steps(2);

        // Test 5: inverted instance
        dA[1] = 8'h40; dB[1] = 8'h00; dC[1] = 8'hFF;
        check("inverted idle A", int'(pA[1]), 1);
        en[1] = 1'b1;
        stepClk();
        clearCounts();
        steps(1024);
        check("inverted high A", hiA[1], 768);
        check("inverted high B", hiB[1], 1024);
        check("inverted high C", hiC[1], 4);
        en[1] = 1'b0;
        steps(2);

        // Test 6: PRESCALE=1 instance
        dA[2] = 8'h01; dB[2] = 8'hFF; dC[2] = 8'h00;
        en[2] = 1'b1;
        stepClk();
        clearCounts();
        steps(512);
        check("prescale1 high A", hiA[2], 2);
        check("prescale1 high B", hiB[2], 510);
        check("prescale1 pulses", perCnt[2], 2);

        // Randomised stimulus on all three instances against the model
        en = 3'b111;
        for (int i = 0; i < 5000; i++) begin
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 63) == 0) dA[d] = 8'($urandom);
                if ($urandom_range(0, 63) == 0) dB[d] = 8'($urandom);
                if ($urandom_range(0, 63) == 0) dC[d] = 8'($urandom);
                if ($urandom_range(0, 599) == 0) en[d] = ~en[d];
            end
            if (i == 2500) begin
                doReset();
                en = 3'b111;
            end
            stepClk();
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
